// File: rtl/program_loader.sv
// Instruction-memory writer: packs a high-byte-first stream into 16-bit words,
// stalls the core during the load and verifies a trailing XOR checksum byte.
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_COUNT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [15:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            fsm_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HIGH  = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

  // Handshake: a byte transfers on a rising edge where in_valid & in_ready;
  // in_ready depends only on registered state, never on in_valid.
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            checksum;
  logic [7:0]            high_byte;
  logic                  accept;

  assign in_ready  = (state == S_HIGH) || (state == S_LOW) || (state == S_CHECK);
  assign cpu_hold  = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      addr              <= '0;
      checksum          <= '0;
      high_byte         <= '0;
      error             <= 1'b0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr     <= '0;
            checksum <= '0;
            error    <= 1'b0;
            state    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (accept) begin
            high_byte <= in_data;
            checksum  <= checksum ^ in_data;
            state     <= S_LOW;
          end
        end
        S_LOW: begin
          if (accept) begin
            mem_write_enable  <= 1'b1;
            mem_write_address <= addr;
            mem_write_data    <= {high_byte, in_data};
            checksum          <= checksum ^ in_data;
            if (addr == LAST_ADDR) begin
              state <= S_CHECK;
            end else begin
              addr  <= addr + 1'b1;
              state <= S_HIGH;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            error <= (in_data != checksum);
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: directed image loads with
// backpressure, bad checksum, mid-load reset and start-while-busy.
module tb_program_loader;

  localparam int AW = 4;
  localparam int WC = 15;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_address;
  logic [15:0]   mem_write_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [2:0]    fsm_state;

  program_loader #(.ADDR_WIDTH(AW), .WORD_COUNT(WC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_write_enable(mem_write_enable),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hold_cnt = 0;
  logic [AW+15:0] exp_q[$];
  logic           exp_done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [AW+15:0] w;
    logic           e;
    if (cpu_hold) hold_cnt++;
    if (mem_write_enable) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected",
                 mem_write_address, mem_write_data);
      end else begin
        w = exp_q.pop_front();
        check("write_addr_data", {mem_write_address, mem_write_data}, 32'(w));
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done pulse with none expected");
      end else begin
        e = exp_done_q.pop_front();
        check("done_error", 32'(error), 32'(e));
        check("done_cpu_hold", 32'(cpu_hold), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    if (gaps) begin
      repeat ($urandom_range(1, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fsm_state != 3'd0 || cpu_hold) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 32'(n < 200), 32'd1);
  endtask

  task automatic run_load(input bit gaps, input bit busy, input logic [7:0] chk,
                          input bit exp_err, input bit check_len);
    int h0;
    for (int k = 0; k < WC; k++) exp_q.push_back({AW'(k), 16'(k + 1)});
    exp_done_q.push_back(exp_err);
    h0 = hold_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("error_clear_on_start", 32'(error), 32'd0);
    check("cpu_hold_after_start", 32'(cpu_hold), 32'd1);
    for (int k = 0; k < WC; k++) begin
      start = busy && (k == 2);
      send_byte(8'h00, gaps);
      send_byte(8'(k + 1), gaps);
    end
    start = 1'b0;
    send_byte(chk, gaps);
    wait_idle();
    if (check_len) check("hold_cycles", 32'(hold_cnt - h0), 32'(2 * WC + 2));
    check("write_queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    check({tag, "_addr"}, 32'(mem_write_address), 32'd0);
    check({tag, "_data"}, 32'(mem_write_data), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    start    = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 32'(cpu_hold), 32'd0);

    // nominal load, valid held high, checksum of 0x00,0x01..0x00,0x0F is 0x00
    run_load(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // bad checksum, error sticky until next start
    run_load(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
    check("error_sticky_idle", 32'(error), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("error_sticky_later", 32'(error), 32'd1);

    // backpressure with gaps between every byte
    run_load(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // reset after three words written
    for (int k = 0; k < 3; k++) exp_q.push_back({AW'(k), 16'(k + 1)});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h00, 1'b0);
      send_byte(8'(k + 1), 1'b0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    check("midreset_queue_drained", 32'(exp_q.size()), 32'd0);
    run_load(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // start pulsed while busy in HIGH and LOW
    run_load(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    run_load(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("final_idle_hold", 32'(cpu_hold), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
